ps2_direction_rx: RTL

// - PS/2 keyboard receiver and scan-code decoder. Drives the snake game's direction inputs from a real keyboard.
// - Replaces the slide-switch l/r/u/d inputs to keyboard_reader; outputs l/r/u/d are drop-in level-compatible.
// - Receives device-to-host PS/2 frames, checks framing/parity, tracks E0/F0 prefixes, holds per-key pressed state.
// - Arrow keys and WASD both map to directions.

---
 rtl/ps2_direction_rx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver: frames device-to-host bytes, tracks E0/F0 prefixes and
// turns arrow keys / WASD into level-held l/r/u/d plus a last-direction register.
module ps2_direction_rx #(
    parameter int TIMEOUT  = 100000,
    parameter int SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       l,
    output logic       r,
    output logic       u,
    output logic       d,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
    // Abort decided one cycle early so the registered frame_err lands TIMEOUT cycles after the last fe.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_LEN-1:0] dat_sync_q, dat_sync_d;
    logic                clk_prev_q, clk_prev_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [7:0]          sr_q, sr_d;
    logic                perr_q, perr_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [3:0]          lvl_q, lvl_d;        // {d, u, r, l}
    logic [1:0]          dir_q, dir_d;
    logic                dir_valid_q, dir_valid_d;
    logic [7:0]          scan_code_q, scan_code_d;
    logic                code_valid_q, code_valid_d;
    logic                frame_err_q, frame_err_d;

    logic                clk_s, dat_s, fe;
    logic [2:0]          key;

    // Returns {hit, direction index}; index order matches dir encoding.
    function automatic logic [2:0] key_map(input logic ext, input logic [7:0] code);
        logic [2:0] res;
        res = 3'b000;
        if (ext) begin
            case (code)
                8'h6B:   res = 3'b100;
                8'h74:   res = 3'b101;
                8'h75:   res = 3'b110;
                8'h72:   res = 3'b111;
                default: res = 3'b000;
            endcase
        end else begin
            case (code)
                8'h1C:   res = 3'b100;
                8'h23:   res = 3'b101;
                8'h1D:   res = 3'b110;
                8'h1B:   res = 3'b111;
                default: res = 3'b000;
            endcase
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        perr_d       = perr_q;
        to_cnt_d     = to_cnt_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        lvl_d        = lvl_q;
        dir_d        = dir_q;
        dir_valid_d  = 1'b0;
        scan_code_d  = scan_code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        clk_s      = clk_sync_q[SYNC_LEN-1];
        dat_s      = dat_sync_q[SYNC_LEN-1];
        clk_sync_d = {clk_sync_q[SYNC_LEN-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_LEN-2:0], ps2_dat};
        clk_prev_d = clk_s;
        fe         = clk_prev_q & ~clk_s;
        key        = key_map(ext_q, scan_code_q);

        // Receive FSM
        if (state_q == IDLE) begin
            to_cnt_d = '0;
            if (fe && !dat_s) begin
                state_d = DATA;
                cnt_d   = 3'd0;
            end
        end else if (fe) begin
            to_cnt_d = '0;
            case (state_q)
                DATA: begin
                    sr_d = {dat_s, sr_q[7:1]};
                    if (cnt_q == 3'd7) state_d = PARITY;
                    else               cnt_d   = cnt_q + 3'd1;
                end
                PARITY: begin
                    perr_d  = ~(^sr_q ^ dat_s);
                    state_d = STOP;
                end
                default: begin
                    if (dat_s && !perr_q) begin
                        scan_code_d  = sr_q;
                        code_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            to_cnt_d    = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // Scan-code decoder, one cycle behind the receiver
        if (code_valid_q) begin
            case (scan_code_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (key[2]) begin
                        if (brk_q) begin
                            lvl_d[key[1:0]] = 1'b0;
                        end else begin
                            lvl_d[key[1:0]] = 1'b1;
                            dir_d           = key[1:0];
                            dir_valid_d     = 1'b1;
                        end
                    end
                end
            endcase
        end else if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            clk_prev_q   <= 1'b1;
            cnt_q        <= 3'd0;
            sr_q         <= 8'h00;
            perr_q       <= 1'b0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            lvl_q        <= 4'b0000;
            dir_q        <= 2'd1;
            dir_valid_q  <= 1'b0;
            scan_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_prev_q   <= clk_prev_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            perr_q       <= perr_d;
            to_cnt_q     <= to_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            lvl_q        <= lvl_d;
            dir_q        <= dir_d;
            dir_valid_q  <= dir_valid_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign l          = lvl_q[0];
    assign r          = lvl_q[1];
    assign u          = lvl_q[2];
    assign d          = lvl_q[3];
    assign dir        = dir_q;
    assign dir_valid  = dir_valid_q;
    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule
